// File: rtl/vec_lsu_multibeat.sv
// Multi-beat vector load/store unit: moves an R-lane vector over a BEAT_LANES-wide memory port.
// Optional base-alignment check enabled by defining VEC_LSU_ALIGN_CHECK_EN (adds AlignErr output).

module vec_lsu_lane #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q <= '0;
        else if (en) q <= d;
    end
endmodule

module vec_lsu_multibeat #(
    parameter int R          = 6,
    parameter int N          = 8,
    parameter int A          = 32,
    parameter int BEAT_LANES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           StartM,
    input  logic                           WriteEnM,
    input  logic                           FlushM,
    input  logic [A-1:0]                   AddrM,
    input  logic [R-1:0][N-1:0]            WriteDataM,
    output logic [R-1:0][N-1:0]            ReadDataM,
    output logic                           StallM,
    output logic                           Done,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [A-1:0]                   mem_addr,
    output logic [BEAT_LANES-1:0][N-1:0]   mem_wdata,
    input  logic [BEAT_LANES-1:0][N-1:0]   mem_rdata,
    input  logic                           mem_ack
`ifdef VEC_LSU_ALIGN_CHECK_EN
    ,
    output logic                           AlignErr
`endif
);
    localparam int BEATS = R / BEAT_LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (R % BEAT_LANES != 0) begin : g_bad_cfg
            $error("vec_lsu_multibeat: R must be a multiple of BEAT_LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    typedef struct packed {
        logic [A-1:0]        addr;
        logic [R-1:0][N-1:0] data;
        logic                we;
    } req_t;

    state_t          state, state_nxt;
    req_t            req_q;
    logic [BW-1:0]   beat;
    logic            xfer, accept, last_beat, beat_ack, load_cap, unaligned;
    logic [A-1:0]    beat_off;
    logic [R-1:0]    lane_en;

    assign xfer      = (state == XFER);
    assign accept    = (state == IDLE) && StartM && !FlushM;
    assign last_beat = (beat == BW'(BEATS - 1));
    // Flush beats ack: an acked beat on a flush cycle is neither counted nor captured.
    assign beat_ack  = xfer && mem_ack && !FlushM;
    assign load_cap  = beat_ack && !req_q.we;

`ifdef VEC_LSU_ALIGN_CHECK_EN
    logic align_err_q;
    assign unaligned = ((AddrM % A'(BEAT_LANES)) != '0);
    assign AlignErr  = (state == DONE) && align_err_q;
`else
    assign unaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = unaligned ? DONE : XFER;
            XFER: begin
                if (FlushM)                    state_nxt = IDLE;
                else if (mem_ack && last_beat) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q <= '0;
            beat  <= '0;
`ifdef VEC_LSU_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else if (accept) begin
            req_q.addr <= AddrM;
            req_q.data <= WriteDataM;
            req_q.we   <= WriteEnM;
            beat       <= '0;
`ifdef VEC_LSU_ALIGN_CHECK_EN
            align_err_q <= unaligned;
`endif
        end else if (beat_ack && !last_beat) begin
            beat <= beat + 1'b1;
        end
    end

    // Address arithmetic is modulo 2^A; wrap past the top is intentional.
    assign beat_off = A'(beat) * A'(BEAT_LANES);
    assign mem_req  = xfer && !FlushM;
    assign mem_we   = xfer && req_q.we;
    assign mem_addr = xfer ? (req_q.addr + beat_off) : '0;

    always_comb begin
        mem_wdata = '0;
        if (xfer) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat == BW'(b)) mem_wdata = req_q.data[b*BEAT_LANES +: BEAT_LANES];
            end
        end
    end

    // Gated by reset so the hold releases immediately on an asynchronous reset.
    assign StallM = reset && (((state == IDLE) && StartM) || xfer);
    assign Done   = (state == DONE);

    generate
        for (genvar l = 0; l < R; l++) begin : g_lane
            assign lane_en[l] = load_cap && (beat == BW'(l / BEAT_LANES));
            vec_lsu_lane #(.N(N)) u_lane (
                .clk   (clk),
                .reset (reset),
                .en    (lane_en[l]),
                .d     (mem_rdata[l % BEAT_LANES]),
                .q     (ReadDataM[l])
            );
        end
    endgenerate
endmodule

// File: tb/tb_vec_lsu_multibeat.sv
// Directed bench for vec_lsu_multibeat with a small byte-lane memory model behind the beat port.
// Covers VEC_LSU_ALIGN_CHECK_EN when the macro is defined for both files.

module tb_vec_lsu_multibeat;
    logic             clk = 1'b0;
    logic             reset;
    logic             StartM, WriteEnM, FlushM;
    logic [31:0]      AddrM;
    logic [5:0][7:0]  WriteDataM;
    logic [5:0][7:0]  ReadDataM;
    logic             StallM, Done, mem_req, mem_we, mem_ack;
    logic [31:0]      mem_addr;
    logic [1:0][7:0]  mem_wdata, mem_rdata;
`ifdef VEC_LSU_ALIGN_CHECK_EN
    logic             AlignErr;
`endif

    logic             wait_mode;
    logic             ack_r;
    logic [7:0]       mem [256];
    logic [7:0]       ra;
    int               checks = 0;
    int               errors = 0;
    int               cyc;

    always #5 clk = ~clk;

    vec_lsu_multibeat #(.R(6), .N(8), .A(32), .BEAT_LANES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartM     (StartM),
        .WriteEnM   (WriteEnM),
        .FlushM     (FlushM),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .Done       (Done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef VEC_LSU_ALIGN_CHECK_EN
        ,
        .AlignErr   (AlignErr)
`endif
    );

    // Memory model: one wait state per beat in wait_mode, otherwise always ready.
    assign ra        = mem_addr[7:0];
    assign mem_rdata = {mem[ra + 8'd1], mem[ra]};
    assign mem_ack   = wait_mode ? ack_r : 1'b1;

    always @(posedge clk) begin
        ack_r <= wait_mode && mem_req && !ack_r;
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_req && mem_we && mem_ack) begin
            mem[ra]        <= mem_wdata[0];
            mem[ra + 8'd1] <= mem_wdata[1];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (Done !== 1'b1 && n < 20) begin
            nxt();
            n++;
        end
    endtask

    function automatic logic [47:0] mem_vec(input logic [7:0] base);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = mem[8'(base + 8'(i))];
        return v;
    endfunction

    initial begin
        reset = 1'b0; StartM = 1'b0; WriteEnM = 1'b0; FlushM = 1'b0;
        AddrM = '0; WriteDataM = '0; wait_mode = 1'b0; ack_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   64'(mem_req),   64'd0);
        chk("rst_stall", 64'(StallM),    64'd0);
        chk("rst_done",  64'(Done),      64'd0);
        chk("rst_rdata", 64'(ReadDataM), 64'd0);
        reset = 1'b1;
        nxt();

        // T1: store 6 lanes to 0x10, ack tied high
        AddrM = 32'h10; WriteDataM = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        WriteEnM = 1'b1; StartM = 1'b1;
        #1 chk("t1_stall_start", 64'(StallM), 64'd1);
        nxt();
        for (int b = 0; b < 3; b++) begin
            chk("t1_req",   64'(mem_req),   64'd1);
            chk("t1_we",    64'(mem_we),    64'd1);
            chk("t1_addr",  64'(mem_addr),  64'(32'h10 + 32'(2*b)));
            chk("t1_wdata", 64'(mem_wdata), 64'(((2*b+2) << 8) | (2*b+1)));
            chk("t1_stall", 64'(StallM),    64'd1);
            nxt();
        end
        chk("t1_done",      64'(Done),    64'd1);
        chk("t1_stall_end", 64'(StallM),  64'd0);
        chk("t1_req_end",   64'(mem_req), 64'd0);
        StartM = 1'b0; WriteEnM = 1'b0;
        nxt();
        chk("t1_done_pulse", 64'(Done), 64'd0);
        chk("t1_mem", 64'(mem_vec(8'h10)), 64'h0000_0605_0403_0201);

        // T2: load back with one wait state per beat
        wait_mode = 1'b1; AddrM = 32'h10; StartM = 1'b1;
        wait_done(cyc);
        chk("t2_latency", 64'(cyc), 64'd7);
        chk("t2_rdata", 64'(ReadDataM), 64'h0000_0605_0403_0201);
        StartM = 1'b0; wait_mode = 1'b0;
        nxt();
        chk("t2_rdata_hold", 64'(ReadDataM), 64'h0000_0605_0403_0201);

        // FlushM in IDLE masks a request
        StartM = 1'b1; FlushM = 1'b1;
        nxt();
        StartM = 1'b0; FlushM = 1'b0;
        #1 chk("idle_flush_req", 64'(mem_req), 64'd0);
        chk("idle_flush_stall", 64'(StallM), 64'd0);

        // T3: flush during beat 1 of a store to 0x20
        AddrM = 32'h20; WriteDataM = {8'h10, 8'h0f, 8'h0e, 8'h0d, 8'h0c, 8'h0b};
        WriteEnM = 1'b1; StartM = 1'b1;
        nxt();
        nxt();
        FlushM = 1'b1; StartM = 1'b0;
        #1 chk("t3_req_flush", 64'(mem_req), 64'd0);
        nxt();
        FlushM = 1'b0;
        chk("t3_req_after",   64'(mem_req), 64'd0);
        chk("t3_no_done",     64'(Done),    64'd0);
        chk("t3_stall_after", 64'(StallM),  64'd0);
        chk("t3_mem", 64'(mem_vec(8'h20)), 64'h0000_0000_0000_0c0b);
        WriteEnM = 1'b0; StartM = 1'b1;
        wait_done(cyc);
        chk("t3_next_latency", 64'(cyc), 64'd4);
        chk("t3_next_rdata", 64'(ReadDataM), 64'h0000_0000_0000_0c0b);
        StartM = 1'b0;
        nxt();

        // T4: asynchronous reset in the middle of a load
        AddrM = 32'h10; StartM = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
        #1;
        chk("t4_req",   64'(mem_req),   64'd0);
        chk("t4_stall", 64'(StallM),    64'd0);
        chk("t4_done",  64'(Done),      64'd0);
        chk("t4_rdata", 64'(ReadDataM), 64'd0);
        StartM = 1'b0;
        nxt();
        reset = 1'b1;
        nxt();

        // T5: address wrap, store then load at 0xFFFFFFFE
        AddrM = 32'hFFFF_FFFE; WriteDataM = {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};
        WriteEnM = 1'b1; StartM = 1'b1;
        wait_done(cyc);
        StartM = 1'b0; WriteEnM = 1'b0;
        nxt();
        StartM = 1'b1;
        nxt();
        for (int b = 0; b < 3; b++) begin
            logic [31:0] ea;
            ea = 32'hFFFF_FFFE + 32'(2*b);
            chk("t5_addr", 64'(mem_addr), 64'(ea));
            nxt();
        end
        chk("t5_done",  64'(Done),      64'd1);
        chk("t5_rdata", 64'(ReadDataM), 64'h0000_2625_2423_2221);
        StartM = 1'b0;
        nxt();

`ifdef VEC_LSU_ALIGN_CHECK_EN
        // T6: unaligned base raises AlignErr without memory beats
        AddrM = 32'h11; StartM = 1'b1;
        nxt();
        chk("t6_req",   64'(mem_req),   64'd0);
        chk("t6_done",  64'(Done),      64'd1);
        chk("t6_err",   64'(AlignErr),  64'd1);
        chk("t6_rdata", 64'(ReadDataM), 64'h0000_2625_2423_2221);
        StartM = 1'b0;
        nxt();
        chk("t6_err_pulse", 64'(AlignErr), 64'd0);
`else
        // Unaligned base is accessed beat-by-beat from the given address
        AddrM = 32'h11; StartM = 1'b1;
        nxt();
        chk("t6_unal_addr", 64'(mem_addr), 64'h11);
        wait_done(cyc);
        chk("t6_unal_latency", 64'(cyc), 64'd3);
        StartM = 1'b0;
        nxt();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
